// File: rtl/cnt_stream_checker.sv
// Receive-side checker for a +1 counter stream: acquires lock, flywheels through
// isolated glitches, counts sequence errors and drops lock after repeated misses.
module cnt_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     din,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  // Run counters compare against the last step so they never exceed their limit.
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  logic              have_prev_r;
  logic [WIDTH-1:0]  prev_r;
  logic [GW-1:0]     good_run_r;
  logic [BW-1:0]     bad_run_r;
  logic              match_s;
  logic              err_s;

  function automatic logic [WIDTH-1:0] inc_word(input logic [WIDTH-1:0] w);
    return w + WIDTH'(1);
  endfunction

  // Sequence match and error qualification for the current sample.
  always_comb begin
    match_s = 1'b0;
    err_s   = 1'b0;
    if (have_prev_r && (din == inc_word(prev_r))) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
    if (en && (state_r == LOCKED) && !match_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Lock state machine, flywheel tracking and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      have_prev_r <= 1'b0;
      prev_r      <= '0;
      good_run_r  <= '0;
      bad_run_r   <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      expected    <= WIDTH'(1);
    end else begin
      err_pulse <= err_s;

      // An error in the same cycle as a clear leaves exactly that one error.
      if (err_s) begin
        if (clr_err) begin
          err_count <= ERR_CNT_W'(1);
        end else if (err_count != {ERR_CNT_W{1'b1}}) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end else begin
          err_count <= err_count;
        end
      end else if (clr_err) begin
        err_count <= '0;
      end else begin
        err_count <= err_count;
      end

      if (en) begin
        case (state_r)
          HUNT: begin
            prev_r      <= din;
            have_prev_r <= 1'b1;
            expected    <= inc_word(din);
            if (match_s) begin
              if (good_run_r == LOCK_LAST) begin
                state_r    <= LOCKED;
                locked     <= 1'b1;
                good_run_r <= '0;
                bad_run_r  <= '0;
              end else begin
                good_run_r <= good_run_r + GW'(1);
              end
            end else begin
              good_run_r <= '0;
            end
          end
          LOCKED: begin
            if (match_s) begin
              prev_r    <= din;
              expected  <= inc_word(din);
              bad_run_r <= '0;
            end else begin
              // Flywheel: advance as if the word had been correct.
              prev_r   <= inc_word(prev_r);
              expected <= inc_word(inc_word(prev_r));
              if (bad_run_r == LOSS_LAST) begin
                state_r    <= HUNT;
                locked     <= 1'b0;
                good_run_r <= '0;
                bad_run_r  <= '0;
              end else begin
                bad_run_r <= bad_run_r + BW'(1);
              end
            end
          end
          default: begin
            state_r    <= HUNT;
            locked     <= 1'b0;
            good_run_r <= '0;
            bad_run_r  <= '0;
          end
        endcase
      end
    end
  end

endmodule
